// File: rtl/shifter_pkg.sv
// Shared encodings for the sequential shifter: shift modes and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Width of a per-cycle shift count able to hold 0..step.
  function automatic int step_cnt_width(input int step);
    return (step < 1) ? 1 : $clog2(step + 1);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational multi-bit shift stage: applies k single-bit shifts (0..STEP)
// of the selected mode and reports the last bit moved out (or into bit 0 for ROL).
// Carry is 0 when k is 0; the caller only uses it when k is nonzero.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int KW    = step_cnt_width(STEP)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       mode,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH-1:0] d;
  logic             c;

  // Unrolled chain of STEP single-bit stages, each enabled while its index is below k.
  always_comb begin
    d = data;
    c = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(k)) begin
        case (mode_e'(mode))
          MODE_SLL: begin
            c = d[WIDTH-1];
            d = {d[WIDTH-2:0], 1'b0};
          end
          MODE_SRL: begin
            c = d[0];
            d = {1'b0, d[WIDTH-1:1]};
          end
          MODE_SRA: begin
            c = d[0];
            d = {d[WIDTH-1], d[WIDTH-1:1]};
          end
          default: begin
            c = d[WIDTH-1];
            d = {d[WIDTH-2:0], d[WIDTH-1]};
          end
        endcase
      end
    end
    result = d;
    carry  = c;
  end

endmodule

// File: rtl/shifter_seq.sv
// Sequential shifter: accepts one request, shifts up to STEP bits per cycle,
// then holds the result until the consumer takes it.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   ST_IDLE  | waiting for a request, in_ready high
//   ST_SHIFT | applying min(rem, STEP) shifts per cycle
//   ST_DONE  | result held stable, out_valid high
module shifter_seq
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  localparam int KW = step_cnt_width(STEP);

  state_e           state, state_nx;
  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   rem_q;
  logic [SHW-1:0]   rem_nx;
  mode_e            mode_q;
  logic             carry_q;

  logic [KW-1:0]    k;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  // Per-cycle shift count k = min(rem, STEP) and the remaining count after it.
  always_comb begin
    if (int'(rem_q) < STEP) begin
      k = KW'(rem_q);
    end else begin
      k = KW'(STEP);
    end
    rem_nx = rem_q - SHW'(k);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_shift_step (
    .data   (data_q),
    .mode   (mode_q),
    .k      (k),
    .result (step_data),
    .carry  (step_carry)
  );

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; in_valid only matters in IDLE so a held result is never overwritten.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_nx = (in_shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rem_nx == '0) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Working registers: captured on accept, updated every SHIFT cycle, frozen in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_SLL;
      carry_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            rem_q   <= in_shamt;
            mode_q  <= mode_e'(in_mode);
            carry_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          data_q  <= step_data;
          rem_q   <= rem_nx;
          carry_q <= step_carry;
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake and result outputs decoded straight from state and registers.
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    out_data  = data_q;
    out_carry = carry_q;
    out_zero  = (data_q == '0);
  end

endmodule

// File: tb/tb_shifter_seq.sv
// Self-checking bench for shifter_seq: a shift-operator reference model feeds
// a scoreboard queue at accept time; results are popped when out_valid appears.
module tb_shifter_seq;

  localparam int W    = 32;
  localparam int STEP = 4;
  localparam int SHW  = 5;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [SHW-1:0] in_shamt;
  logic [1:0]     in_mode;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_carry;
  logic           out_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    int           lat;
  } exp_t;

  exp_t sb[$];

  shifter_seq #(.WIDTH(W), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model using whole-word shift operators.
  function automatic exp_t model(input logic [W-1:0] d, input logic [SHW-1:0] s,
                                 input logic [1:0] m);
    exp_t r;
    int   n;
    n     = int'(s);
    r.lat = (n + STEP - 1) / STEP;
    case (m)
      2'b00: begin
        r.data  = d << n;
        r.carry = (n == 0) ? 1'b0 : d[W-n];
      end
      2'b01: begin
        r.data  = d >> n;
        r.carry = (n == 0) ? 1'b0 : d[n-1];
      end
      2'b10: begin
        r.data  = W'($signed(d) >>> n);
        r.carry = (n == 0) ? 1'b0 : d[n-1];
      end
      default: begin
        r.data  = (n == 0) ? d : ((d << n) | (d >> (W - n)));
        r.carry = (n == 0) ? 1'b0 : r.data[0];
      end
    endcase
    return r;
  endfunction

  // Issue one request, wait for the result, compare against the scoreboard, release it.
  task automatic run_op(input string name, input logic [W-1:0] d,
                        input logic [SHW-1:0] s, input logic [1:0] m);
    exp_t e;
    int   lat;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    else pass_cnt++;
    in_valid = 1'b1; in_data = d; in_shamt = s; in_mode = m;
    sb.push_back(model(d, s, m));
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    total_cnt++;
    if (lat !== e.lat) $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== e.data || out_carry !== e.carry || out_zero !== (e.data == '0))
      $display("FAIL %s result: got data=%h carry=%b zero=%b want data=%h carry=%b zero=%b",
               name, out_data, out_carry, out_zero, e.data, e.carry, (e.data == '0));
    else pass_cnt++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_shamt = 5'd3;
    in_mode = 2'b11; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_carry !== 1'b0 || out_zero !== 1'b1)
      $display("FAIL reset_state: got rdy=%b vld=%b data=%h carry=%b zero=%b want 1 0 0 0 1",
               in_ready, out_valid, out_data, out_carry, out_zero);
    else pass_cnt++;
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_scenarios();
    run_op("sll_1_by_2",  32'h0000_0001, 5'd2,  2'b00);
    run_op("sra_msb_31",  32'h8000_0000, 5'd31, 2'b10);
    run_op("srl_f_by_3",  32'h0000_000F, 5'd3,  2'b01);
    run_op("rol_8001_4",  32'h8000_0001, 5'd4,  2'b11);
    run_op("sll_to_zero", 32'h0000_0001, 5'd31, 2'b00);
    run_op("sll_carry",   32'hC000_0000, 5'd1,  2'b00);
    run_op("rol_31",      32'h0000_0001, 5'd31, 2'b11);
    run_op("srl_step_5",  32'hFFFF_FFFF, 5'd5,  2'b01);
    run_op("sra_pos_8",   32'h7FFF_0000, 5'd8,  2'b10);
  endtask

  task automatic test_hold_and_ignore();
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hA5A5_0000; in_shamt = 5'd0; in_mode = 2'b01;
    sb.push_back(model(32'hA5A5_0000, 5'd0, 2'b01));
    @(negedge clk);
    in_data = 32'h1234_5678; in_shamt = 5'd7; in_mode = 2'b00;
    e = sb.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL hold_zero_latency: got out_valid=%b want 1", out_valid);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== e.data || out_carry !== e.carry)
        $display("FAIL hold_stable[%0d]: got vld=%b rdy=%b data=%h carry=%b want 1 0 %h %b",
                 i, out_valid, in_ready, out_data, out_carry, e.data, e.carry);
      else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== e.data)
      $display("FAIL hold_ignored_request: got vld=%b rdy=%b data=%h want 0 1 %h",
               out_valid, in_ready, out_data, e.data);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h8000_0000; in_shamt = 5'd31; in_mode = 2'b10;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_zero !== 1'b1)
      $display("FAIL abort_state: got rdy=%b vld=%b data=%h zero=%b want 1 0 0 1",
               in_ready, out_valid, out_data, out_zero);
    else pass_cnt++;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    out_ready = 1'b0;
    total_cnt++;
    if (seen !== 0) $display("FAIL abort_no_done: got %0d out_valid cycles want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0]   d;
    logic [SHW-1:0] s;
    logic [1:0]     m;
    for (int i = 0; i < 24; i++) begin
      d = $urandom;
      s = SHW'($urandom_range(0, W - 1));
      m = 2'($urandom_range(0, 3));
      run_op($sformatf("rand%0d", i), d, s, m);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = 2'b00; out_ready = 1'b0;
    test_reset();
    test_scenarios();
    test_hold_and_ignore();
    test_reset_mid_shift();
    test_random();
    total_cnt++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/shifter_seq.md
SHIFTER_SEQ -- requirements
Module: shifter_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width; it must be a power of two and at least 8.
REQ-002 The block SHALL have parameter STEP, default 4, giving the maximum shift distance per cycle; legal range is 1..WIDTH.
REQ-003 The block SHALL have derived parameter SHW = clog2(WIDTH), default 5, giving the shift-amount width.
REQ-004 Port clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-005 Port rst_n  input  1  is the synchronous, active-low reset.
REQ-006 Port in_valid  input  1  indicates the request is valid.
REQ-007 Port in_ready  output  1  indicates the block can accept a request.
REQ-008 Port in_data  input  WIDTH  is the operand.
REQ-009 Port in_shamt  input  SHW  is the shift amount, 0..WIDTH-1.
REQ-010 Port in_mode  input  2  selects the mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-011 Port out_valid  output  1  indicates the result is valid.
REQ-012 Port out_ready  input  1  indicates the consumer accepts the result.
REQ-013 Port out_data  output  WIDTH  is the shifted result.
REQ-014 Port out_carry  output  1  is the last bit shifted out (SLL/SRL/SRA), or the last bit rotated into bit 0 (ROL).
REQ-015 Port out_zero  output  1  SHALL be high when out_data == 0.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-017 An accept (in_valid && in_ready at an edge) SHALL capture data, shamt into a remaining counter rem, and mode, and SHALL clear carry.
REQ-018 After an accept, the FSM SHALL go to DONE if shamt == 0, else to SHIFT.
REQ-019 In SHIFT, each edge SHALL apply k = min(rem, STEP) single-bit shifts of the held mode, set rem = rem - k, and update carry.
REQ-020 In SHIFT, the FSM SHALL go to DONE on the edge where rem reaches 0.
REQ-021 SLL SHALL fill with 0; SRL SHALL fill with 0; SRA SHALL fill with the current MSB; ROL SHALL rotate MSB into LSB.
REQ-022 Latency SHALL be exactly ceil(shamt/STEP) edges after the accept edge until out_valid is seen (0 edges for shamt == 0, i.e. out_valid is high in the cycle after accept).
REQ-023 In DONE, out_data, out_carry and out_zero SHALL stay stable until out_valid && out_ready; on that edge the FSM SHALL return to IDLE.
REQ-024 in_valid SHALL be ignored outside IDLE; no request may be lost or overwritten.
REQ-025 out_data SHALL reflect the working register in all states, but its value SHALL be defined for the consumer only in DONE.
REQ-026 A single-bit shift with STEP == 1 SHALL give identical results to any other STEP, differing only in latency.

Reset
REQ-027 With rst_n low at an edge, the block SHALL set state = IDLE, data = 0, rem = 0, mode = 00 and carry = 0, giving in_ready = 1, out_valid = 0, out_data = 0, out_carry = 0 and out_zero = 1.
REQ-028 Reset SHALL take priority over any accept or handshake in the same cycle.
REQ-029 Reset SHALL abort an operation mid-SHIFT or mid-DONE with no result emitted.

Structure
REQ-030 Package shifter_pkg SHALL hold the mode encodings (SLL, SRL, SRA, ROL) and the state enum.
REQ-031 Sub-module shift_step SHALL be combinational: it takes data, mode and k (0..STEP) and returns the shifted data and carry.
REQ-032 shifter_seq SHALL contain only the FSM, the registers and one shift_step instance.

Verification
REQ-033 Scenario: SLL 0x0000_0001 by 2, STEP 4 -> out_data 0x0000_0004, carry 0, out_valid 1 edge after accept.
REQ-034 Scenario: SRA 0x8000_0000 by 31 -> out_data 0xFFFF_FFFF, carry 0, latency 8 edges.
REQ-035 Scenario: SRL 0x0000_000F by 3 -> out_data 0x0000_0001, carry 1.
REQ-036 Scenario: ROL 0x8000_0001 by 4 -> out_data 0x0000_0018, carry 0.
REQ-037 Scenario: shamt 0 with out_ready held low 5 cycles -> output is stable, in_ready is 0, and a second in_valid is ignored; the result is released on the out_ready edge.
REQ-038 Scenario: rst_n low during SHIFT -> next cycle in_ready 1, out_valid 0, out_data 0, out_zero 1, and no DONE occurs.
